// File: rtl/ecc_failure_monitor.sv
// RS decoder failure monitor: queues sigma degree per codeword, counts Chien roots
// per scan, and emits a tagged pass/fail verdict with saturating link statistics.
module ecc_failure_monitor #(
    parameter int unsigned W     = 10,
    parameter int unsigned T     = 15,
    parameter int unsigned P     = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [W*(T+1)-1:0]       sigma_low_i,
    input  logic                     sigma_valid_i,
    input  logic [TAG_W-1:0]         sigma_tag_i,
    input  logic                     chien_busy_i,
    input  logic                     chien_done_i,
    input  logic [P-1:0]             hit_mask_i,
    input  logic                     stat_clr_i,
    output logic                     result_valid_o,
    output logic [TAG_W-1:0]         result_tag_o,
    output logic                     exceed_o,
    output logic [1:0]               reason_o,
    output logic [$clog2(T+1)-1:0]   deg_o,
    output logic [$clog2(T+2)-1:0]   roots_o,
    output logic                     q_full_o,
    output logic                     overflow_o,
    output logic [CNT_W-1:0]         cw_cnt_o,
    output logic [CNT_W-1:0]         fail_cnt_o
);

    localparam int unsigned DEG_W = $clog2(T + 1);
    localparam int unsigned RT_W  = $clog2(T + 2);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned PC_W  = $clog2(P + 1);
    localparam int unsigned SUM_W = ((RT_W > PC_W) ? RT_W : PC_W) + 1;

    localparam logic [RT_W-1:0] ROOT_SAT = RT_W'(T + 1);

    localparam logic [1:0] RSN_OK       = 2'b00;
    localparam logic [1:0] RSN_MISMATCH = 2'b01;
    localparam logic [1:0] RSN_ROOTS   = 2'b10;
    localparam logic [1:0] RSN_EMPTY    = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DEG_W-1:0] q_deg [DEPTH];
    logic [TAG_W-1:0] q_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [RT_W-1:0]  acc, acc_nxt;

    logic [DEG_W-1:0] sig_deg;
    logic [PC_W-1:0]  hit_cnt;
    logic [SUM_W-1:0] sum;
    logic [RT_W-1:0]  roots_now;
    logic             q_empty, q_full, push_ok, pop, drop, full_nxt;
    logic [DEG_W-1:0] head_deg;
    logic [TAG_W-1:0] head_tag;
    logic [1:0]       reason_now;

    logic             valid_nxt, exceed_nxt, ovf_nxt;
    logic [TAG_W-1:0] tag_nxt;
    logic [1:0]       reason_nxt;
    logic [DEG_W-1:0] deg_nxt;
    logic [RT_W-1:0]  roots_nxt;
    logic [CNT_W-1:0] cw_nxt, fail_nxt;

    // Degree of sigma: highest nonzero coefficient index.
    always_comb begin
        sig_deg = '0;
        for (int unsigned i = 0; i < T + 1; i++) begin
            if (sigma_low_i[i*W +: W] != '0) sig_deg = DEG_W'(i);
        end
    end

    always_comb begin
        hit_cnt = '0;
        for (int unsigned i = 0; i < P; i++) begin
            hit_cnt = hit_cnt + PC_W'(hit_mask_i[i]);
        end
    end

    // Next-state logic for the scan FSM, queue, verdict and statistics.
    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        valid_nxt  = 1'b0;
        tag_nxt    = result_tag_o;
        exceed_nxt = exceed_o;
        reason_nxt = reason_o;
        deg_nxt    = deg_o;
        roots_nxt  = roots_o;
        cw_nxt     = cw_cnt_o;
        fail_nxt   = fail_cnt_o;
        ovf_nxt    = overflow_o;

        q_empty  = (wr_ptr == rd_ptr);
        q_full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        head_deg = q_deg[rd_ptr[AW-1:0]];
        head_tag = q_tag[rd_ptr[AW-1:0]];

        pop      = chien_done_i && !q_empty;
        push_ok  = sigma_valid_i && (!q_full || pop);
        drop     = sigma_valid_i && q_full && !pop;
        wr_nxt   = wr_ptr + PTR_W'(push_ok);
        rd_nxt   = rd_ptr + PTR_W'(pop);
        full_nxt = (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);

        // Root count including this cycle's hits, saturated at T+1.
        sum = SUM_W'(acc) + SUM_W'(hit_cnt);
        if (chien_busy_i || chien_done_i) begin
            roots_now = (sum >= SUM_W'(ROOT_SAT)) ? ROOT_SAT : RT_W'(sum);
        end else begin
            roots_now = acc;
        end

        if (q_empty) begin
            reason_now = RSN_EMPTY;
        end else if (roots_now == ROOT_SAT) begin
            reason_now = RSN_ROOTS;
        end else if (roots_now != RT_W'(head_deg)) begin
            reason_now = RSN_MISMATCH;
        end else begin
            reason_now = RSN_OK;
        end

        case (state)
            IDLE:    if (chien_busy_i && !chien_done_i) state_nxt = SCAN;
            SCAN:    if (chien_done_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (chien_done_i) begin
            acc_nxt = '0;
        end else if (chien_busy_i) begin
            acc_nxt = roots_now;
        end

        if (chien_done_i) begin
            valid_nxt  = 1'b1;
            tag_nxt    = q_empty ? '0 : head_tag;
            deg_nxt    = q_empty ? '0 : head_deg;
            roots_nxt  = roots_now;
            reason_nxt = reason_now;
            exceed_nxt = (reason_now != RSN_OK);
            if (cw_cnt_o != '1) cw_nxt = cw_cnt_o + CNT_W'(1);
            if ((reason_now != RSN_OK) && (fail_cnt_o != '1)) fail_nxt = fail_cnt_o + CNT_W'(1);
        end

        if (drop) ovf_nxt = 1'b1;

        if (stat_clr_i) begin
            cw_nxt   = '0;
            fail_nxt = '0;
            ovf_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            acc            <= '0;
            result_valid_o <= 1'b0;
            result_tag_o   <= '0;
            exceed_o       <= 1'b0;
            reason_o       <= RSN_OK;
            deg_o          <= '0;
            roots_o        <= '0;
            q_full_o       <= 1'b0;
            overflow_o     <= 1'b0;
            cw_cnt_o       <= '0;
            fail_cnt_o     <= '0;
        end else begin
            state          <= state_nxt;
            wr_ptr         <= wr_nxt;
            rd_ptr         <= rd_nxt;
            acc            <= acc_nxt;
            result_valid_o <= valid_nxt;
            result_tag_o   <= tag_nxt;
            exceed_o       <= exceed_nxt;
            reason_o       <= reason_nxt;
            deg_o          <= deg_nxt;
            roots_o        <= roots_nxt;
            q_full_o       <= full_nxt;
            overflow_o     <= ovf_nxt;
            cw_cnt_o       <= cw_nxt;
            fail_cnt_o     <= fail_nxt;
        end
    end

    // Queue storage needs no reset; the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) begin
            q_deg[wr_ptr[AW-1:0]] <= sig_deg;
            q_tag[wr_ptr[AW-1:0]] <= sigma_tag_i;
        end
    end

endmodule

// File: tb/tb_ecc_failure_monitor.sv
// Bench for ecc_failure_monitor: behavioral queue/root model feeding a verdict
// scoreboard, a table of single-codeword cases, and hand-written corner sequences.
module tb_ecc_failure_monitor;

    localparam int unsigned W     = 10;
    localparam int unsigned T     = 15;
    localparam int unsigned P     = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned DEG_W = 4;
    localparam int unsigned RT_W  = 5;

    logic                 clk;
    logic                 rst;
    logic [W*(T+1)-1:0]   sigma_low;
    logic                 sigma_valid;
    logic [TAG_W-1:0]     sigma_tag;
    logic                 chien_busy;
    logic                 chien_done;
    logic [P-1:0]         hit_mask;
    logic                 stat_clr;
    logic                 result_valid;
    logic [TAG_W-1:0]     result_tag;
    logic                 exceed;
    logic [1:0]           reason;
    logic [DEG_W-1:0]     deg;
    logic [RT_W-1:0]      roots;
    logic                 q_full;
    logic                 overflow;
    logic [CNT_W-1:0]     cw_cnt;
    logic [CNT_W-1:0]     fail_cnt;

    ecc_failure_monitor #(
        .W(W), .T(T), .P(P), .DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sigma_low_i    (sigma_low),
        .sigma_valid_i  (sigma_valid),
        .sigma_tag_i    (sigma_tag),
        .chien_busy_i   (chien_busy),
        .chien_done_i   (chien_done),
        .hit_mask_i     (hit_mask),
        .stat_clr_i     (stat_clr),
        .result_valid_o (result_valid),
        .result_tag_o   (result_tag),
        .exceed_o       (exceed),
        .reason_o       (reason),
        .deg_o          (deg),
        .roots_o        (roots),
        .q_full_o       (q_full),
        .overflow_o     (overflow),
        .cw_cnt_o       (cw_cnt),
        .fail_cnt_o     (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             exceed;
        logic [1:0]       reason;
        logic [DEG_W-1:0] deg;
        logic [RT_W-1:0]  roots;
    } exp_t;

    typedef struct {
        int deg;
        int tag;
    } qent_t;

    typedef struct {
        int sdeg;
        int tag;
        int n_empty;
        int n_hits;
        bit all_ones;
        int done_hits;
        int exp_reason;
        int exp_roots;
    } vec_t;

    exp_t   sb[$];
    qent_t  mq[$];
    int     macc;
    longint mcw, mfail;
    bit     movf;
    int     n_cmp = 0;
    int     n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W*(T+1)-1:0] make_sigma(input int d);
        logic [W*(T+1)-1:0] s;
        int c;
        s = '0;
        for (int i = 0; i <= d; i++) begin
            c = (i == d) ? int'($urandom_range(1, 1023)) : int'($urandom_range(0, 1023));
            s[i*W +: W] = W'(c);
        end
        return s;
    endfunction

    // Scoreboard: every observed verdict pops the oldest expectation.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_verdict", 64'(result_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("verdict_tag", 64'(result_tag), 64'(e.tag));
                chk("verdict_exceed", 64'(exceed), 64'(e.exceed));
                chk("verdict_reason", 64'(reason), 64'(e.reason));
                chk("verdict_deg", 64'(deg), 64'(e.deg));
                chk("verdict_roots", 64'(roots), 64'(e.roots));
            end
        end
    end

    // One clock of stimulus; called at a falling edge, returns at the next one.
    task automatic cycle(input bit r, input bit sv, input int sdeg, input int stag,
                         input bit busy, input bit done, input logic [P-1:0] mask,
                         input bit clr);
        int    r_sum, pre_size;
        bit    popped;
        exp_t  e;
        qent_t h;
        rst         = r;
        sigma_valid = sv;
        sigma_low   = sv ? make_sigma(sdeg) : '0;
        sigma_tag   = sv ? TAG_W'(stag) : '0;
        chien_busy  = busy;
        chien_done  = done;
        hit_mask    = mask;
        stat_clr    = clr;

        if (r) begin
            mq.delete();
            macc  = 0;
            mcw   = 0;
            mfail = 0;
            movf  = 1'b0;
        end else begin
            r_sum = macc;
            if (busy || done) r_sum = macc + $countones(mask);
            if (r_sum > T + 1) r_sum = T + 1;
            pre_size = mq.size();
            popped   = 1'b0;
            if (done) begin
                if (pre_size == 0) begin
                    e.tag = '0; e.deg = '0; e.reason = 2'b11;
                end else begin
                    h = mq.pop_front();
                    popped = 1'b1;
                    e.tag = TAG_W'(h.tag);
                    e.deg = DEG_W'(h.deg);
                    if (r_sum == T + 1)   e.reason = 2'b10;
                    else if (r_sum != h.deg) e.reason = 2'b01;
                    else                  e.reason = 2'b00;
                end
                e.roots  = RT_W'(r_sum);
                e.exceed = (e.reason != 2'b00);
                sb.push_back(e);
                mcw++;
                if (e.exceed) mfail++;
            end
            if (sv) begin
                if (pre_size < DEPTH || popped) mq.push_back('{(sdeg < 0) ? 0 : sdeg, stag});
                else movf = 1'b1;
            end
            if (done)      macc = 0;
            else if (busy) macc = r_sum;
            if (clr) begin
                mcw = 0; mfail = 0; movf = 1'b0;
            end
        end

        @(posedge clk);
        @(negedge clk);
        chk("result_valid", 64'(result_valid), 64'(done && !r));
        chk("q_full", 64'(q_full), 64'(mq.size() == DEPTH));
        chk("overflow", 64'(overflow), 64'(movf));
        chk("cw_cnt", 64'(cw_cnt), 64'(mcw));
        chk("fail_cnt", 64'(fail_cnt), 64'(mfail));
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic push(input int sdeg, input int stag);
        cycle(0, 1, sdeg, stag, 0, 0, '0, 0);
    endtask

    // Scan: zero-hit busy cycles, single-hit busy cycles, optional all-ones cycle, then done.
    task automatic scan(input int n_empty, input int n_hits, input bit all_ones,
                        input int done_hits, input bit sv_on_done, input int sdeg,
                        input int stag);
        logic [P-1:0] m;
        bit any_busy;
        any_busy = (n_empty + n_hits > 0) || all_ones;
        for (int i = 0; i < n_empty; i++) cycle(0, 0, 0, 0, 1, 0, '0, 0);
        for (int i = 0; i < n_hits; i++) begin
            m = '0;
            m[$urandom_range(0, P - 1)] = 1'b1;
            cycle(0, 0, 0, 0, 1, 0, m, 0);
        end
        if (all_ones) cycle(0, 0, 0, 0, 1, 0, '1, 0);
        m = '0;
        for (int k = 0; k < done_hits; k++) m[k] = 1'b1;
        cycle(0, sv_on_done, sdeg, stag, any_busy, 1, m, 0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{3, 5, 0, 3, 1'b0, 0, 0, 3};
        vecs[1] = '{4, 6, 1, 2, 1'b0, 0, 1, 2};
        vecs[2] = '{15, 7, 0, 0, 1'b1, 0, 2, 16};
        vecs[3] = '{-1, 8, 2, 0, 1'b0, 0, 0, 0};
        vecs[4] = '{15, 9, 0, 15, 1'b0, 0, 0, 15};
        vecs[5] = '{2, 10, 0, 20, 1'b0, 0, 2, 16};
        vecs[6] = '{1, 11, 0, 0, 1'b0, 1, 0, 1};
        vecs[7] = '{0, 12, 0, 0, 1'b0, 3, 1, 3};

        macc = 0; mcw = 0; mfail = 0; movf = 1'b0;
        rst = 1'b1; sigma_valid = 1'b0; sigma_low = '0; sigma_tag = '0;
        chien_busy = 1'b0; chien_done = 1'b0; hit_mask = '0; stat_clr = 1'b0;
        @(negedge clk);
        cycle(1, 0, 0, 0, 0, 0, '0, 0);
        cycle(1, 0, 0, 0, 0, 0, '0, 0);
        chk("rst_tag", 64'(result_tag), 64'(0));
        chk("rst_exceed", 64'(exceed), 64'(0));
        chk("rst_reason", 64'(reason), 64'(0));
        chk("rst_deg", 64'(deg), 64'(0));
        chk("rst_roots", 64'(roots), 64'(0));
        idle();

        // Single-codeword cases.
        for (int i = 0; i < 8; i++) begin
            push(vecs[i].sdeg, vecs[i].tag);
            scan(vecs[i].n_empty, vecs[i].n_hits, vecs[i].all_ones, vecs[i].done_hits, 0, 0, 0);
            chk($sformatf("vec%0d_reason", i), 64'(reason), 64'(vecs[i].exp_reason));
            chk($sformatf("vec%0d_roots", i), 64'(roots), 64'(vecs[i].exp_roots));
            chk($sformatf("vec%0d_tag", i), 64'(result_tag), 64'(vecs[i].tag));
            idle();
        end

        // Pipelined: three sigmas queued ahead of their scans.
        push(-1, 1);
        push(2, 2);
        push(1, 3);
        scan(1, 0, 0, 0, 0, 0, 0);
        scan(0, 2, 0, 0, 0, 0, 0);
        scan(0, 1, 0, 0, 0, 0, 0);
        chk("pipe_last_tag", 64'(result_tag), 64'(3));
        idle();

        // Overflow, push+pop at full, drain, and empty-queue verdicts.
        for (int i = 1; i <= DEPTH + 1; i++) push(1, i);
        chk("ovf_sticky", 64'(overflow), 64'(1));
        scan(0, 1, 0, 0, 1, 1, 6);
        for (int i = 0; i < DEPTH; i++) scan(0, 1, 0, 0, 0, 0, 0);
        scan(0, 0, 0, 0, 0, 0, 0);
        chk("empty_reason", 64'(reason), 64'(3));
        chk("empty_tag", 64'(result_tag), 64'(0));
        chk("empty_deg", 64'(deg), 64'(0));
        scan(0, 0, 0, 0, 1, 2, 7);
        chk("push_on_done_reason", 64'(reason), 64'(3));
        scan(0, 2, 0, 0, 0, 0, 0);
        chk("push_on_done_tag", 64'(result_tag), 64'(7));
        cycle(0, 0, 0, 0, 0, 0, '0, 1);
        chk("clr_cw", 64'(cw_cnt), 64'(0));
        chk("clr_ovf", 64'(overflow), 64'(0));
        idle();

        // Reset in the middle of a scan discards its hits.
        cycle(0, 0, 0, 0, 1, 0, 32'h0000_0001, 0);
        cycle(0, 0, 0, 0, 1, 0, 32'h0001_0000, 0);
        cycle(1, 0, 0, 0, 0, 0, '0, 0);
        cycle(0, 0, 0, 0, 0, 1, '0, 0);
        chk("rstscan_reason", 64'(reason), 64'(3));
        chk("rstscan_roots", 64'(roots), 64'(0));
        chk("rstscan_cw", 64'(cw_cnt), 64'(1));

        idle();
        idle();
        chk("pending_verdicts", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ecc_failure_monitor.md
# ecc_failure_monitor

Pipelined decoder-failure monitor for the RS(544,514) decoder back end. It sits between the KES/RiBM output, the parallel Chien search and the Forney/correction stage. It queues the degree of each codeword's σ as soon as KES delivers it, counts Chien roots across each scan, and compares the two per codeword. Each codeword gets a tagged pass/fail verdict with a reason code, and the block keeps saturating link statistics, so back-to-back codewords can overlap KES and Chien without losing the σ degree of the codeword under scan.

## Interface
Parameters:
- W, 10: symbol width (GF(2^W)).
- T, 15: correction capability; σ has T+1 coefficients.
- P, 32: Chien roots tested per cycle (hit_mask width).
- DEPTH, 4: σ-degree queue depth (power of two, ≥2).
- TAG_W, 4: codeword tag width.
- CNT_W, 32: statistics counter width.

Ports (one clock; reset is synchronous and active-high):
- clk_i, in, 1: clock; all logic on rising edge.
- rst_i, in, 1: synchronous active-high reset.
- sigma_low_i, in, W×(T+1): λ0..λT, low order first.
- sigma_valid_i, in, 1: σ (and sigma_tag_i) valid this cycle; push request.
- sigma_tag_i, in, TAG_W: codeword tag accompanying σ.
- chien_busy_i, in, 1: Chien scan in progress.
- chien_done_i, in, 1: final cycle of a scan (single-cycle pulse).
- hit_mask_i, in, P: per-lane root hits this cycle.
- stat_clr_i, in, 1: clear statistics counters.
- result_valid_o, out, 1: verdict pulse.
- result_tag_o, out, TAG_W: tag of judged codeword.
- exceed_o, out, 1: 1 = uncorrectable.
- reason_o, out, 2: 00 OK, 01 root/degree mismatch, 10 roots > T, 11 no σ queued.
- deg_o, out, $clog2(T+1): σ degree used for the verdict.
- roots_o, out, $clog2(T+2): saturated root count.
- q_full_o, out, 1: queue full.
- overflow_o, out, 1: sticky, a σ was dropped.
- cw_cnt_o, out, CNT_W: codewords judged.
- fail_cnt_o, out, CNT_W: codewords with exceed_o=1.

## Operation
- Degree: highest index i with sigma_low_i[i]≠0; all-zero σ gives degree 0. Computed combinationally and pushed with the tag on sigma_valid_i.
- Queue: FIFO of {deg, tag} with DEPTH entries, read/write pointers carrying one extra wrap bit.
  - A push when full (and no pop that cycle) is dropped and sets overflow_o.
  - A push and pop in the same cycle is always accepted, even when full.
  - Occupancy stays unchanged in that case.
- Root counter: a scan FSM with states IDLE and SCAN.
  - In any cycle with chien_busy_i|chien_done_i, add popcount(hit_mask_i) to the accumulator.
  - The accumulator saturates at T+1.
  - IDLE→SCAN on busy with no done. SCAN→IDLE on done.
  - A done with no preceding busy is a one-cycle scan.
  - The accumulator clears the cycle after done.
- Verdict on done, judged against the queue head; pop if non-empty.
  - Reason priority: empty queue → 11; roots = T+1 → 10; roots ≠ deg → 01; else 00.
  - exceed_o = (reason≠00).
  - With an empty queue, tag and deg outputs are 0.
- Statistics:
  - cw_cnt_o increments on every verdict; fail_cnt_o increments on every exceed.
  - Both saturate at all-ones.
  - stat_clr_i zeroes both and wins over a same-cycle increment.
  - stat_clr_i also clears overflow_o.

## Timing
- Reset (rst_i=1 at an edge) does the following:
  - All outputs go to 0, except reason_o=00.
  - Queue empties and the FSM returns to IDLE.
  - Accumulator and counters clear.
  - Reset mid-scan discards the partial count. The next done with an empty queue reports reason 11.
- Verdict latency: result_valid_o and its payload are registered one cycle after chien_done_i.
  - result_valid_o is high for exactly one cycle.
  - The payload holds until the next verdict.
- Statistics update in the same cycle as result_valid_o.
- A σ pushed in the same cycle as done is not visible to that verdict; the pop uses the pre-cycle head.
  - With an empty queue, the pushed entry remains queued.
- q_full_o is registered and reflects post-edge occupancy.
- A done during a scan whose hits saturate still uses the saturated value T+1.

## Test plan
- Basic pass: σ with λ0..λ3 nonzero and the rest 0 (deg 3), tag 5; scan with 3 hits spread over cycles, done → one cycle later result_valid_o=1, tag 5, deg 3, roots 3, reason 00, exceed 0; cw_cnt 1, fail_cnt 0.
- Mismatch: deg 4, scan with 2 hits → reason 01, exceed 1, fail_cnt 1.
- Saturation: deg T, hit_mask all-ones for 1 cycle (P=32 > T+1) → roots T+1, reason 10.
- Pipelining: push tags 1,2,3 (degrees 0,2,1) before any done, then three scans with 0,2,1 hits → three OK verdicts in tag order 1,2,3.
- Overflow and empty: push DEPTH+1 σ with no done → q_full_o=1, overflow_o=1, the last dropped; drain all DEPTH; an extra done → reason 11, tag 0; stat_clr_i → counters 0, overflow_o 0.
- Reset mid-scan: start scan with 2 hits, assert rst_i, then done → verdict reason 11, roots 0; cw_cnt 1.
